// File: rtl/log_move_if.sv
// Frame-strobe inputs and log coordinate / lane status outputs of log_move.
// master drives the frame strobes, slave is the log position generator.
interface log_move_if #(
  parameter int NUM_LOGS  = 15,
  parameter int NUM_LANES = 5
);
  logic                 startOfFrame;
  logic                 freeze;
  logic [10:0]          ObjectStartX [NUM_LOGS-1:0];
  logic [10:0]          ObjectStartY [NUM_LOGS-1:0];
  logic [NUM_LANES-1:0] lane_move;
  logic [NUM_LANES-1:0] lane_dir;
  logic                 update_done;
  logic                 overrun;

  modport master (
    output startOfFrame,
    output freeze,
    input  ObjectStartX,
    input  ObjectStartY,
    input  lane_move,
    input  lane_dir,
    input  update_done,
    input  overrun
  );

  modport slave (
    input  startOfFrame,
    input  freeze,
    output ObjectStartX,
    output ObjectStartY,
    output lane_move,
    output lane_dir,
    output update_done,
    output overrun
  );
endinterface

// File: rtl/log_move.sv
// River log position generator: one log stepped per cycle after each
// frame strobe, with per-lane speed, direction and horizontal wrap.
module log_move #(
  parameter int NUM_LOGS      = 15,
  parameter int LOGS_PER_LANE = 3,
  parameter int NUM_LANES     = 5,
  parameter int LANE0_Y       = 100,
  parameter int LANE_H        = 32,
  parameter int LOG_SPACING   = 220,
  parameter int WRAP_W        = 680,
  parameter int BASE_PERIOD   = 1
) (
  input  logic     CLK,
  input  logic     RESETn,
  log_move_if.slave bus
);

  localparam int IW = $clog2(NUM_LOGS);
  localparam int LW = $clog2(NUM_LANES);
  localparam int SW = $clog2(LOGS_PER_LANE + 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [SW-1:0]        sub_q, sub_d;
  logic [3:0]           cnt_q [NUM_LANES];
  logic [3:0]           cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0] lane_move_q, lane_move_d;
  logic                 update_done_q, update_done_d;
  logic                 overrun_q, overrun_d;
  logic [10:0]          x_q [NUM_LOGS];
  logic [10:0]          x_d [NUM_LOGS];

  function automatic logic [10:0] step(
    input logic [10:0] x,
    input logic        left
  );
    logic [10:0] r;
    if (left) begin
      r = (x == 11'd0) ? 11'(WRAP_W - 1) : x - 11'd1;
    end else begin
      r = (x == 11'(WRAP_W - 1)) ? 11'd0 : x + 11'd1;
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.startOfFrame) state_d = UPDATE;
      end
      UPDATE: begin
        if (idx_q == IW'(NUM_LOGS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d         = idx_q;
    lane_d        = lane_q;
    sub_d         = sub_q;
    cnt_d         = cnt_q;
    lane_move_d   = lane_move_q;
    x_d           = x_q;
    update_done_d = 1'b0;
    overrun_d     = overrun_q
                  | (bus.startOfFrame && state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (bus.startOfFrame) begin
          idx_d  = '0;
          lane_d = '0;
          sub_d  = '0;
          for (int k = 0; k < NUM_LANES; k++) begin
            if (bus.freeze) begin
              lane_move_d[k] = 1'b0;
            end else begin
              lane_move_d[k] =
                (cnt_q[k] == 4'(BASE_PERIOD + k - 1));
              cnt_d[k] = lane_move_d[k] ? 4'd0
                                        : cnt_q[k] + 4'd1;
            end
          end
        end
      end
      UPDATE: begin
        if (lane_move_q[lane_q]) begin
          x_d[idx_q] = step(x_q[idx_q], lane_q[0]);
        end
        idx_d = idx_q + IW'(1);
        if (sub_q == SW'(LOGS_PER_LANE - 1)) begin
          sub_d  = '0;
          lane_d = lane_q + LW'(1);
        end else begin
          sub_d = sub_q + SW'(1);
        end
        if (idx_q == IW'(NUM_LOGS - 1)) update_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      idx_q         <= '0;
      lane_q        <= '0;
      sub_q         <= '0;
      lane_move_q   <= '0;
      update_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) cnt_q[k] <= 4'd0;
      for (int i = 0; i < NUM_LOGS; i++) begin
        x_q[i] <= 11'((i % LOGS_PER_LANE) * LOG_SPACING);
      end
    end else begin
      idx_q         <= idx_d;
      lane_q        <= lane_d;
      sub_q         <= sub_d;
      lane_move_q   <= lane_move_d;
      update_done_q <= update_done_d;
      overrun_q     <= overrun_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
    end
  end

  for (genvar i = 0; i < NUM_LOGS; i++) begin : g_log
    assign bus.ObjectStartX[i] = x_q[i];
    assign bus.ObjectStartY[i] =
      11'(LANE0_Y + (i / LOGS_PER_LANE) * LANE_H);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_dir
    assign bus.lane_dir[k] = 1'(k % 2);
  end

  assign bus.lane_move   = lane_move_q;
  assign bus.update_done = update_done_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_log_move.sv
// Directed bench for log_move: reset, stepping, wrap, overrun,
// freeze and mid-update reset.
module tb_log_move;

  logic CLK;
  logic RESETn;
  int   passed;
  int   total;
  int   lat;

  log_move_if bus ();

  log_move u_dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic frame(
    input  int repulse_at,
    input  int reset_at,
    output int l
  );
    l = 0;
    @(negedge CLK);
    bus.startOfFrame = 1'b1;
    @(negedge CLK);
    bus.startOfFrame = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == repulse_at)     bus.startOfFrame = 1'b1;
      if (c == repulse_at + 1) bus.startOfFrame = 1'b0;
      if (c == reset_at)       RESETn = 1'b0;
      if (c == reset_at + 1)   RESETn = 1'b1;
      if (bus.update_done && l == 0) l = c;
      if (l != 0 && c > repulse_at + 1 && c > reset_at + 1)
        break;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    RESETn = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.freeze = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    check("rst_x0", bus.ObjectStartX[0], 0);
    check("rst_x1", bus.ObjectStartX[1], 220);
    check("rst_x2", bus.ObjectStartX[2], 440);
    check("rst_y0", bus.ObjectStartY[0], 100);
    check("rst_y3", bus.ObjectStartY[3], 132);
    check("rst_y14", bus.ObjectStartY[14], 228);
    check("rst_move", bus.lane_move, 0);
    check("rst_done", bus.update_done, 0);
    check("rst_ovr", bus.overrun, 0);
    check("lane_dir", bus.lane_dir, 5'b01010);

    frame(0, 0, lat);
    check("f1_lat", lat, 15);
    @(negedge CLK);
    check("f1_done_1cyc", bus.update_done, 0);
    check("f1_x0", bus.ObjectStartX[0], 1);
    check("f1_x1", bus.ObjectStartX[1], 221);
    check("f1_x2", bus.ObjectStartX[2], 441);
    check("f1_x3", bus.ObjectStartX[3], 0);
    check("f1_x6", bus.ObjectStartX[6], 0);
    check("f1_move", bus.lane_move, 5'b00001);

    frame(0, 0, lat);
    check("f2_lat", lat, 15);
    check("f2_x0", bus.ObjectStartX[0], 2);
    check("f2_x3_wrap", bus.ObjectStartX[3], 679);
    check("f2_x4", bus.ObjectStartX[4], 219);
    check("f2_move", bus.lane_move, 5'b00011);

    for (int f = 0; f < 237; f++) frame(0, 0, lat);
    check("f239_x2", bus.ObjectStartX[2], 679);
    frame(0, 0, lat);
    check("f240_x2_wrap", bus.ObjectStartX[2], 0);
    check("f240_x0", bus.ObjectStartX[0], 240);
    check("f240_x3", bus.ObjectStartX[3], 560);
    check("f240_x12", bus.ObjectStartX[12], 48);
    check("f240_move", bus.lane_move, 5'b11111);
    check("f240_ovr", bus.overrun, 0);
    check("f240_y14", bus.ObjectStartY[14], 228);

    do_reset();
    frame(5, 0, lat);
    check("ovr_lat", lat, 15);
    @(negedge CLK);
    check("ovr_done_1cyc", bus.update_done, 0);
    check("ovr_x0", bus.ObjectStartX[0], 1);
    check("ovr_x1", bus.ObjectStartX[1], 221);
    check("ovr_x3", bus.ObjectStartX[3], 0);
    check("ovr_flag", bus.overrun, 1);
    frame(0, 0, lat);
    check("ovr_x3_f2", bus.ObjectStartX[3], 679);
    check("ovr_sticky", bus.overrun, 1);

    bus.freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, lat);
      check("frz_lat", lat, 15);
      check("frz_move", bus.lane_move, 0);
    end
    check("frz_x0", bus.ObjectStartX[0], 2);
    check("frz_x3", bus.ObjectStartX[3], 679);
    bus.freeze = 1'b0;
    frame(0, 0, lat);
    check("thaw_move", bus.lane_move, 5'b00101);
    check("thaw_x0", bus.ObjectStartX[0], 3);
    check("thaw_x6", bus.ObjectStartX[6], 1);

    frame(0, 7, lat);
    check("mrst_no_done", lat, 0);
    check("mrst_x0", bus.ObjectStartX[0], 0);
    check("mrst_x1", bus.ObjectStartX[1], 220);
    check("mrst_x3", bus.ObjectStartX[3], 0);
    check("mrst_x6", bus.ObjectStartX[6], 0);
    check("mrst_move", bus.lane_move, 0);
    check("mrst_ovr", bus.overrun, 0);
    frame(0, 0, lat);
    check("post_lat", lat, 15);
    check("post_x0", bus.ObjectStartX[0], 1);
    check("post_move", bus.lane_move, 5'b00001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
